// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter with a
// leading-zero blank mask and an overflow flag. The result registers are
// updated only on the LOAD edge, so downstream displays never see a partial
// conversion.
module bin_to_bcd_seq #(
    parameter int unsigned IN_W   = 20,
    parameter int unsigned DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf
);

    localparam int unsigned        CNT_W     = $clog2(IN_W + 1);
    localparam logic [DIGITS-1:0]  BLANK_RST = {DIGITS{1'b1}} << 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_e;

    state_e                state_q, state_d;
    logic [IN_W-1:0]       shift_q, shift_d;
    logic [4*DIGITS-1:0]   work_q,  work_d;
    logic                  carry_q, carry_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [4*DIGITS-1:0]   bcd_q,   bcd_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic                  ovf_q,   ovf_d;
    logic                  done_q,  done_d;

    logic [4*DIGITS-1:0]   adj;
    logic [DIGITS-1:0]     blank_calc;
    logic                  upper_zero;

    // Add-3 correction: every working digit >= 5 is bumped before the shift.
    always_comb begin
        adj = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            adj[4*d +: 4] = (work_q[4*d +: 4] >= 4'd5) ? (work_q[4*d +: 4] + 4'd3)
                                                       : work_q[4*d +: 4];
        end
    end

    // Leading-zero mask from the finished working digits, scanned from the top.
    always_comb begin
        blank_calc = '0;
        upper_zero = 1'b1;
        for (int unsigned i = 0; i + 1 < DIGITS; i++) begin
            upper_zero = upper_zero & (work_q[4*(DIGITS-1-i) +: 4] == 4'd0);
            blank_calc[DIGITS-1-i] = upper_zero;
        end
    end

    // Next-state and datapath control for the IDLE -> SHIFT -> LOAD sequence.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        work_d  = work_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin_in;
                    work_d  = '0;
                    carry_d = 1'b0;
                    cnt_d   = CNT_W'(IN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A bit leaving the top digit carries weight 10^DIGITS; it is
                // only remembered as overflow, the digits keep the remainder.
                shift_d = shift_q << 1;
                work_d  = {adj[4*DIGITS-2:0], shift_q[IN_W-1]};
                carry_d = carry_q | adj[4*DIGITS-1];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bcd_d   = work_q;
                blank_d = blank_calc;
                ovf_d   = carry_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            blank_q <= BLANK_RST;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign blank = blank_q;
    assign ovf   = ovf_q;

endmodule
